// File: rtl/modular_addsub_pipe_pkg.sv
// modular_addsub_pipe_pkg: shared moduli, lane geometry, mode encoding and Kyber half correction
package modular_addsub_pipe_pkg;
  localparam int LW = 24;
  localparam int HW = 12;
  localparam int KYBER_Q = 3329;
  localparam int DIL_Q = 8380417;
  typedef enum logic [1:0] {MODE_KADD, MODE_KSUB, MODE_DADD, MODE_DSUB} mode_t;
  function automatic logic [HW-1:0] kfix(input logic [HW:0] s, input logic sub, input logic [HW:0] q);
    return sub ? (s[HW] ? s[HW-1:0] + q[HW-1:0] : s[HW-1:0])
               : (s >= q ? s[HW-1:0] - q[HW-1:0] : s[HW-1:0]);
  endfunction
endpackage

// File: rtl/modular_addsub_pipe_lane.sv
// modadd_lane: one 24-bit lane, stage-1 raw add/sub with range flag, stage-2 modular correction
module modadd_lane
  import modular_addsub_pipe_pkg::*;
#(
  parameter int KQ = KYBER_Q,
  parameter int DQ = DIL_Q
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [LW-1:0] a,
  input  logic [LW-1:0] b,
  output logic [LW-1:0] sum,
  output logic          oor
);
  localparam logic [HW:0] KQ1 = (HW+1)'(KQ);
  localparam logic [LW:0] DQ1 = (LW+1)'(DQ);
  logic [HW:0] hs, ls;
  logic [LW:0] ds;
  logic [2*HW+1:0] raw, r1;
  logic [1:0] m1;
  logic o1, rng;
  logic [LW-1:0] fix;
  always_comb begin
    hs = mode[0] ? {1'b0, a[LW-1:HW]} - {1'b0, b[LW-1:HW]} : {1'b0, a[LW-1:HW]} + {1'b0, b[LW-1:HW]};
    ls = mode[0] ? {1'b0, a[HW-1:0]} - {1'b0, b[HW-1:0]} : {1'b0, a[HW-1:0]} + {1'b0, b[HW-1:0]};
    ds = mode[0] ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    raw = mode[1] ? {1'b0, ds} : {hs, ls};
    rng = mode[1] ? ({1'b0, a} >= DQ1 || {1'b0, b} >= DQ1)
                  : ({1'b0, a[LW-1:HW]} >= KQ1 || {1'b0, a[HW-1:0]} >= KQ1 ||
                     {1'b0, b[LW-1:HW]} >= KQ1 || {1'b0, b[HW-1:0]} >= KQ1);
  end
  always_comb begin
    fix = m1[1] ? (m1[0] ? (r1[LW] ? r1[LW-1:0] + DQ1[LW-1:0] : r1[LW-1:0])
                         : (r1[LW:0] >= DQ1 ? r1[LW-1:0] - DQ1[LW-1:0] : r1[LW-1:0]))
                : {kfix(r1[2*HW+1:HW+1], m1[0], KQ1), kfix(r1[HW:0], m1[0], KQ1)};
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      m1 <= '0;
      r1 <= '0;
      o1 <= 1'b0;
      sum <= '0;
      oor <= 1'b0;
    end else if (en) begin
      m1 <= mode;
      r1 <= raw;
      o1 <= rng;
      sum <= fix;
      oor <= o1;
    end
  end
endmodule

// File: rtl/modular_addsub_pipe.sv
// modular_addsub_pipe: multi-lane Kyber/Dilithium modular add/sub, 2-stage valid/ready pipeline with A delay line
module modular_addsub_pipe
  import modular_addsub_pipe_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DLY   = 6,
  parameter int TAG_W = 8,
  parameter int KQ    = KYBER_Q,
  parameter int DQ    = DIL_Q
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_mode,
  input  logic                in_sel_dly,
  input  logic [LW*LANES-1:0] in_a,
  input  logic [LW*LANES-1:0] in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LW*LANES-1:0] out_sum,
  output logic [TAG_W-1:0]    out_tag,
  output logic [LANES-1:0]    out_oor
);
  logic en, acc, v1;
  logic [TAG_W-1:0] t1;
  logic [LW*LANES-1:0] dl [DLY];
  logic [LW*LANES-1:0] a_op;
  assign en = ~out_valid | out_ready;
  assign in_ready = en;
  assign acc = in_valid & en;
  assign a_op = in_sel_dly ? dl[DLY-1] : in_a;
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1 <= 1'b0;
      t1 <= '0;
      out_valid <= 1'b0;
      out_tag <= '0;
      for (int i = 0; i < DLY; i++) dl[i] <= '0;
    end else begin
      if (en) begin
        v1 <= in_valid;
        t1 <= in_tag;
        out_valid <= v1;
        out_tag <= t1;
      end
      if (acc) begin
        dl[0] <= in_a;
        for (int i = 1; i < DLY; i++) dl[i] <= dl[i-1];
      end
    end
  end
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    modadd_lane #(.KQ(KQ), .DQ(DQ)) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .mode(in_mode),
      .a   (a_op[LW*g +: LW]),
      .b   (in_b[LW*g +: LW]),
      .sum (out_sum[LW*g +: LW]),
      .oor (out_oor[g])
    );
  end
endmodule
